// File: rtl/alu_result_buffer.sv
// alu_result_buffer: valid/ready FIFO of ALU results with write-enable decode and overflow status.
// Optional overflow trap handshake enabled by defining ALU_RESULT_OVF_TRAP_EN.
module alu_result_buffer #(
    parameter int DEPTH = 2,
    parameter int REG_W = 5
) (
    input  logic                      CLK,
    input  logic                      RST_N,
    input  logic                      IN_VALID,
    output logic                      IN_READY,
    input  logic [31:0]               ALU_OUT,
    input  logic                      OVF,
    input  logic                      TEST,
    input  logic                      ALU_SIGNED,
    input  logic [REG_W-1:0]          DEST,
    output logic                      OUT_VALID,
    input  logic                      OUT_READY,
    output logic [31:0]               C_OUT,
    output logic [REG_W-1:0]          C_DEST,
    output logic                      C_WE,
    output logic [$clog2(DEPTH):0]    COUNT,
    output logic                      OVF_STICKY,
    input  logic                      OVF_CLR,
`ifdef ALU_RESULT_OVF_TRAP_EN
    output logic                      TRAP_REQ,
    input  logic                      TRAP_ACK,
`endif
    output logic [7:0]                OVF_CNT
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [31:0]      data_q [DEPTH];
    logic [31:0]      data_d [DEPTH];
    logic [REG_W-1:0] dest_q [DEPTH];
    logic [REG_W-1:0] dest_d [DEPTH];
    logic [DEPTH-1:0] we_q, we_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             sticky_q, sticky_d;
    logic [7:0]       ovf_cnt_q, ovf_cnt_d;
    logic             push, pop, eovf, we_in, ovf_push, trap_block;

`ifdef ALU_RESULT_OVF_TRAP_EN
    logic trap_q, trap_d;
    assign trap_block = trap_q;
    assign TRAP_REQ   = trap_q;
`else
    assign trap_block = 1'b0;
`endif

    assign eovf      = OVF & ALU_SIGNED & ~TEST;
    assign we_in     = ~eovf & (DEST != '0);
    assign IN_READY  = (count_q < CNT_W'(DEPTH)) & ~trap_block;
    assign OUT_VALID = count_q != '0;
    assign push      = IN_VALID & IN_READY;
    assign pop       = OUT_VALID & OUT_READY;
    assign ovf_push  = push & eovf;
    assign C_OUT     = OUT_VALID ? data_q[rd_ptr_q] : '0;
    assign C_DEST    = OUT_VALID ? dest_q[rd_ptr_q] : '0;
    assign C_WE      = OUT_VALID & we_q[rd_ptr_q];
    assign COUNT     = count_q;
    assign OVF_STICKY = sticky_q;
    assign OVF_CNT   = ovf_cnt_q;

    // Write the incoming result into the tail slot on a push.
    always_comb begin
        data_d = data_q;
        dest_d = dest_q;
        we_d   = we_q;
        if (push) begin
            data_d[wr_ptr_q] = ALU_OUT;
            dest_d[wr_ptr_q] = DEST;
            we_d[wr_ptr_q]   = we_in;
        end
    end

    // Pointer and occupancy updates; pointers wrap naturally at DEPTH.
    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
    end

    // Overflow status: a new overflow push wins over a clear in the same cycle.
    always_comb begin
        sticky_d  = ovf_push ? 1'b1 : (OVF_CLR ? 1'b0 : sticky_q);
        ovf_cnt_d = OVF_CLR ? {7'd0, ovf_push}
                  : (ovf_push && ovf_cnt_q != 8'hFF) ? ovf_cnt_q + 8'd1 : ovf_cnt_q;
    end

`ifdef ALU_RESULT_OVF_TRAP_EN
    // Trap request latches on an overflow push and holds until acknowledged.
    always_comb begin
        trap_d = ovf_push ? 1'b1 : (TRAP_ACK ? 1'b0 : trap_q);
    end

    // Trap request register.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) trap_q <= 1'b0;
        else        trap_q <= trap_d;
    end
`endif

    // State registers; reset discards every held entry.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            data_q    <= '{default: '0};
            dest_q    <= '{default: '0};
            we_q      <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            sticky_q  <= 1'b0;
            ovf_cnt_q <= '0;
        end else begin
            data_q    <= data_d;
            dest_q    <= dest_d;
            we_q      <= we_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            sticky_q  <= sticky_d;
            ovf_cnt_q <= ovf_cnt_d;
        end
    end
endmodule

// File: tb/tb_alu_result_buffer.sv
// tb_alu_result_buffer: directed self-checking bench for alu_result_buffer with DEPTH=2.
module tb_alu_result_buffer;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, ovf, test, alu_signed;
    logic [31:0] alu_out, c_out;
    logic [4:0]  dest, c_dest;
    logic        out_valid, out_ready, c_we, ovf_sticky, ovf_clr;
    logic [1:0]  count;
    logic [7:0]  ovf_cnt;
`ifdef ALU_RESULT_OVF_TRAP_EN
    logic        trap_req, trap_ack;
`endif
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    alu_result_buffer #(.DEPTH(2), .REG_W(5)) dut (
        .CLK(clk), .RST_N(rst_n), .IN_VALID(in_valid), .IN_READY(in_ready),
        .ALU_OUT(alu_out), .OVF(ovf), .TEST(test), .ALU_SIGNED(alu_signed), .DEST(dest),
        .OUT_VALID(out_valid), .OUT_READY(out_ready), .C_OUT(c_out), .C_DEST(c_dest),
        .C_WE(c_we), .COUNT(count), .OVF_STICKY(ovf_sticky), .OVF_CLR(ovf_clr),
`ifdef ALU_RESULT_OVF_TRAP_EN
        .TRAP_REQ(trap_req), .TRAP_ACK(trap_ack),
`endif
        .OVF_CNT(ovf_cnt)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] d, input logic [4:0] r,
                         input logic o, input logic s, input logic t);
        in_valid = v; alu_out = d; dest = r; ovf = o; alu_signed = s; test = t;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; out_ready = 1'b0; ovf_clr = 1'b0;
`ifdef ALU_RESULT_OVF_TRAP_EN
        trap_ack = 1'b0;
`endif
        drive(1'b0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        step(); step();
        rst_n = 1'b1;
        step();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid); end
        checks++; if (c_out !== 32'd0) begin failures++; $display("FAIL reset_c_out got=%h exp=0", c_out); end
        checks++; if (count !== 2'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%0b exp=1", in_ready); end
        checks++; if (ovf_cnt !== 8'd0 || ovf_sticky !== 1'b0) begin failures++; $display("FAIL reset_ovf got=%0d/%0b exp=0/0", ovf_cnt, ovf_sticky); end
    endtask

    task automatic test_single_push();
        drive(1'b1, 32'h0000_00A5, 5'd3, 1'b0, 1'b0, 1'b0);
        step();
        drive(1'b0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL single_out_valid got=%0b exp=1", out_valid); end
        checks++; if (c_out !== 32'hA5) begin failures++; $display("FAIL single_c_out got=%h exp=000000a5", c_out); end
        checks++; if (c_dest !== 5'd3) begin failures++; $display("FAIL single_c_dest got=%0d exp=3", c_dest); end
        checks++; if (c_we !== 1'b1) begin failures++; $display("FAIL single_c_we got=%0b exp=1", c_we); end
        checks++; if (count !== 2'd1) begin failures++; $display("FAIL single_count got=%0d exp=1", count); end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        checks++; if (count !== 2'd0 || out_valid !== 1'b0) begin failures++; $display("FAIL single_pop count/valid got=%0d/%0b exp=0/0", count, out_valid); end
        checks++; if (c_out !== 32'd0 || c_dest !== 5'd0 || c_we !== 1'b0) begin failures++; $display("FAIL single_empty_outputs got=%h/%0d/%0b exp=0/0/0", c_out, c_dest, c_we); end
    endtask

    task automatic test_full();
        drive(1'b1, 32'h11, 5'd1, 1'b0, 1'b0, 1'b0);
        step();
        checks++; if (count !== 2'd1 || in_ready !== 1'b1) begin failures++; $display("FAIL full_first count/ready got=%0d/%0b exp=1/1", count, in_ready); end
        drive(1'b1, 32'h22, 5'd2, 1'b0, 1'b0, 1'b0);
        step();
        checks++; if (count !== 2'd2 || in_ready !== 1'b0) begin failures++; $display("FAIL full_second count/ready got=%0d/%0b exp=2/0", count, in_ready); end
        drive(1'b1, 32'h33, 5'd3, 1'b0, 1'b0, 1'b0);
        step();
        checks++; if (count !== 2'd2 || c_out !== 32'h11) begin failures++; $display("FAIL full_reject count/head got=%0d/%h exp=2/00000011", count, c_out); end
        out_ready = 1'b1;
        step();
        checks++; if (count !== 2'd1 || c_out !== 32'h22 || c_dest !== 5'd2) begin failures++; $display("FAIL full_pop_no_push count/head/dest got=%0d/%h/%0d exp=1/00000022/2", count, c_out, c_dest); end
        drive(1'b1, 32'h44, 5'd4, 1'b0, 1'b0, 1'b0);
        step();
        checks++; if (count !== 2'd1 || c_out !== 32'h44 || c_dest !== 5'd4) begin failures++; $display("FAIL full_push_pop count/head/dest got=%0d/%h/%0d exp=1/00000044/4", count, c_out, c_dest); end
        drive(1'b1, 32'h55, 5'd5, 1'b0, 1'b0, 1'b0);
        out_ready = 1'b0;
        step();
        drive(1'b0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        checks++; if (count !== 2'd2 || c_out !== 32'h44) begin failures++; $display("FAIL full_wrap_fill count/head got=%0d/%h exp=2/00000044", count, c_out); end
        out_ready = 1'b1;
        step();
        checks++; if (count !== 2'd1 || c_out !== 32'h55 || c_dest !== 5'd5) begin failures++; $display("FAIL full_wrap_order count/head/dest got=%0d/%h/%0d exp=1/00000055/5", count, c_out, c_dest); end
        step();
        out_ready = 1'b0;
        checks++; if (count !== 2'd0) begin failures++; $display("FAIL full_drain count got=%0d exp=0", count); end
    endtask

    task automatic test_overflow();
        drive(1'b1, 32'h8000_0000, 5'd7, 1'b1, 1'b1, 1'b0);
        step();
        drive(1'b0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        checks++; if (c_we !== 1'b0 || c_out !== 32'h8000_0000) begin failures++; $display("FAIL ovf_entry we/data got=%0b/%h exp=0/80000000", c_we, c_out); end
        checks++; if (ovf_sticky !== 1'b1 || ovf_cnt !== 8'd1) begin failures++; $display("FAIL ovf_status sticky/cnt got=%0b/%0d exp=1/1", ovf_sticky, ovf_cnt); end
        out_ready = 1'b1;
        drive(1'b1, 32'd1, 5'd7, 1'b1, 1'b1, 1'b1);
        step();
        out_ready = 1'b0;
        drive(1'b0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        checks++; if (c_we !== 1'b1 || c_out !== 32'd1 || ovf_cnt !== 8'd1) begin failures++; $display("FAIL ovf_test_result we/data/cnt got=%0b/%h/%0d exp=1/00000001/1", c_we, c_out, ovf_cnt); end
        out_ready = 1'b1;
        drive(1'b1, 32'h7, 5'd9, 1'b1, 1'b0, 1'b0);
        step();
        out_ready = 1'b0;
        drive(1'b0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        checks++; if (c_we !== 1'b1 || ovf_cnt !== 8'd1) begin failures++; $display("FAIL ovf_unsigned we/cnt got=%0b/%0d exp=1/1", c_we, ovf_cnt); end
        out_ready = 1'b1;
        drive(1'b1, 32'h9, 5'd0, 1'b0, 1'b0, 1'b0);
        step();
        drive(1'b0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        checks++; if (c_we !== 1'b0 || c_out !== 32'h9 || c_dest !== 5'd0) begin failures++; $display("FAIL r0_entry we/data/dest got=%0b/%h/%0d exp=0/00000009/0", c_we, c_out, c_dest); end
        drive(1'b1, 32'hA, 5'd2, 1'b1, 1'b1, 1'b0);
        step();
        checks++; if (ovf_cnt !== 8'd2) begin failures++; $display("FAIL ovf_second cnt got=%0d exp=2", ovf_cnt); end
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        drive(1'b0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        checks++; if (ovf_sticky !== 1'b1 || ovf_cnt !== 8'd1) begin failures++; $display("FAIL clr_vs_push sticky/cnt got=%0b/%0d exp=1/1", ovf_sticky, ovf_cnt); end
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        checks++; if (ovf_sticky !== 1'b0 || ovf_cnt !== 8'd0) begin failures++; $display("FAIL clr_only sticky/cnt got=%0b/%0d exp=0/0", ovf_sticky, ovf_cnt); end
        step();
        out_ready = 1'b0;
        checks++; if (count !== 2'd0) begin failures++; $display("FAIL ovf_drain count got=%0d exp=0", count); end
    endtask

    task automatic test_saturate();
        out_ready = 1'b1;
        drive(1'b1, 32'hFFFF_FFFF, 5'd4, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 254; i++) step();
        checks++; if (ovf_cnt !== 8'd254) begin failures++; $display("FAIL sat_254 cnt got=%0d exp=254", ovf_cnt); end
        for (int i = 0; i < 6; i++) step();
        drive(1'b0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        checks++; if (ovf_cnt !== 8'd255 || ovf_sticky !== 1'b1) begin failures++; $display("FAIL sat_260 cnt/sticky got=%0d/%0b exp=255/1", ovf_cnt, ovf_sticky); end
        step();
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        drive(1'b1, 32'h1234, 5'd6, 1'b0, 1'b0, 1'b0);
        step();
        drive(1'b1, 32'h5678, 5'd8, 1'b0, 1'b0, 1'b0);
        step();
        drive(1'b0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        checks++; if (count !== 2'd2) begin failures++; $display("FAIL mid_fill count got=%0d exp=2", count); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (count !== 2'd0 || out_valid !== 1'b0) begin failures++; $display("FAIL mid_reset count/valid got=%0d/%0b exp=0/0", count, out_valid); end
        checks++; if (c_out !== 32'd0 || c_dest !== 5'd0 || c_we !== 1'b0) begin failures++; $display("FAIL mid_reset_outputs got=%h/%0d/%0b exp=0/0/0", c_out, c_dest, c_we); end
        checks++; if (ovf_cnt !== 8'd0 || ovf_sticky !== 1'b0) begin failures++; $display("FAIL mid_reset_ovf got=%0d/%0b exp=0/0", ovf_cnt, ovf_sticky); end
        step();
        rst_n = 1'b1;
        step();
        checks++; if (in_ready !== 1'b1 || count !== 2'd0) begin failures++; $display("FAIL mid_release ready/count got=%0b/%0d exp=1/0", in_ready, count); end
    endtask

`ifdef ALU_RESULT_OVF_TRAP_EN
    task automatic test_trap();
        drive(1'b1, 32'h1, 5'd1, 1'b0, 1'b0, 1'b0);
        step();
        drive(1'b1, 32'h2, 5'd2, 1'b1, 1'b1, 1'b0);
        step();
        drive(1'b1, 32'h3, 5'd3, 1'b0, 1'b0, 1'b0);
        checks++; if (trap_req !== 1'b1 || in_ready !== 1'b0) begin failures++; $display("FAIL trap_set req/ready got=%0b/%0b exp=1/0", trap_req, in_ready); end
        out_ready = 1'b1;
        step();
        checks++; if (count !== 2'd1 || c_out !== 32'h2 || trap_req !== 1'b1) begin failures++; $display("FAIL trap_drain count/head/req got=%0d/%h/%0b exp=1/00000002/1", count, c_out, trap_req); end
        drive(1'b0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        trap_ack = 1'b1;
        step();
        trap_ack = 1'b0;
        out_ready = 1'b0;
        checks++; if (trap_req !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("FAIL trap_ack req/ready got=%0b/%0b exp=0/1", trap_req, in_ready); end
    endtask
`endif

    initial begin
        test_reset();
        test_single_push();
        test_full();
        test_overflow();
        test_saturate();
        test_reset_mid();
`ifdef ALU_RESULT_OVF_TRAP_EN
        test_trap();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
